// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder and its byte-merge helper.
package dm_pkg;

    localparam int DM_WORD_BITS = 32;
    localparam int DM_WORDS     = 3072;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_e;

    // True when a word index falls inside a memory of the given depth.
    function automatic logic dm_in_range(input logic [29:0] idx, input int words);
        return ({2'b00, idx} < 32'(words));
    endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Combinational byte-lane merge: lanes with byteen set take wdata, others keep the old word.
module dm_byte_merge
    import dm_pkg::*;
(
    input  logic [DM_WORD_BITS-1:0] old_word,
    input  logic [DM_WORD_BITS-1:0] wdata,
    input  logic [3:0]              byteen,
    output logic [DM_WORD_BITS-1:0] merged
);

    // Select each byte lane independently.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder with fixed wait-state latency for the MIPS MEM stage.
// Optional store trace printing is enabled by defining DM_TRACE_EN.
module dm_responder
    import dm_pkg::*;
#(
    parameter int WORDS   = DM_WORDS,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    dm_state_e                  state_r;
    logic [3:0]                 count_r;
    logic                       we_r;
    logic [29:0]                idx_r;
    logic [3:0]                 byteen_r;
    logic [DM_WORD_BITS-1:0]    wdata_r;
    logic [DM_WORD_BITS-1:0]    mem_r [WORDS];

    logic                       in_range_s;
    logic                       access_s;
    logic [IW-1:0]              widx_s;
    logic [DM_WORD_BITS-1:0]    old_word_s;
    logic [DM_WORD_BITS-1:0]    merged_s;
    logic                       unused_s;

    // Decode of the access cycle and the addressed word.
    always_comb begin
        in_range_s = dm_in_range(idx_r, WORDS);
        access_s   = (state_r == WAIT) && (count_r == 4'd0);
        widx_s     = idx_r[IW-1:0];
        if (in_range_s) begin
            old_word_s = mem_r[widx_s];
        end else begin
            old_word_s = '0;
        end
    end

    dm_byte_merge u_merge (
        .old_word (old_word_s),
        .wdata    (wdata_r),
        .byteen   (byteen_r),
        .merged   (merged_s)
    );

    // Request FSM, latched request fields and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            count_r  <= 4'd0;
            we_r     <= 1'b0;
            idx_r    <= 30'd0;
            byteen_r <= 4'd0;
            wdata_r  <= 32'd0;
            ack      <= 1'b0;
            rdata    <= 32'd0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack <= 1'b0;
                    err <= 1'b0;
                    if (req) begin
                        we_r     <= we;
                        idx_r    <= addr[31:2];
                        byteen_r <= byteen;
                        wdata_r  <= wdata;
                        count_r  <= 4'(LATENCY - 1);
                        busy     <= 1'b1;
                        state_r  <= WAIT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                WAIT: begin
                    if (count_r != 4'd0) begin
                        count_r <= count_r - 4'd1;
                    end else begin
                        ack     <= 1'b1;
                        err     <= ~in_range_s;
                        state_r <= RESP;
                        if (!in_range_s) begin
                            rdata <= 32'd0;
                        end else if (!we_r) begin
                            rdata <= old_word_s;
                        end else begin
                            rdata <= rdata;
                        end
                    end
                end
                RESP: begin
                    ack     <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    ack     <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Storage array; reset clears every word so a dropped request leaves no trace.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (access_s && we_r && in_range_s) begin
            mem_r[widx_s] <= merged_s;
        end else begin
            mem_r[widx_s] <= mem_r[widx_s];
        end
    end

`ifdef DM_TRACE_EN
    logic [31:0] pc_r;

    // PC of the accepted request, kept only for the store trace.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= 32'd0;
        end else if (state_r == IDLE && req) begin
            pc_r <= pc;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Trace line for each committed in-range store that touches at least one lane.
    always_ff @(posedge clk) begin
        if (access_s && we_r && in_range_s && (byteen_r != 4'd0)) begin
            $display("%d@%h: *%h <= %h", $time, pc_r, {idx_r, 2'b00}, merged_s);
        end
    end

    assign unused_s = ^{addr[1:0]};
`else
    assign unused_s = ^{addr[1:0], pc};
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (WORDS=3072, LATENCY=2).
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    dm_responder #(.WORDS(3072), .LATENCY(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .pc     (pc),
        .ack    (ack),
        .rdata  (rdata),
        .err    (err),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete request; returns the data and err sampled in the ack cycle.
    task automatic do_access(input string tag, input logic w, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] d,
                             output logic [31:0] rd, output logic e);
        int cyc;
        bit got;
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; byteen = be; wdata = d;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) check({tag, "_busy_acc"}, {31'd0, busy}, 32'd1);
            if (ack === 1'b1) got = 1'b1;
        end
        check({tag, "_latency"}, cyc, 32'd3);
        check({tag, "_busy_ack"}, {31'd0, busy}, 32'd1);
        rd = rdata;
        e  = err;
        req = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ack_width"}, {31'd0, ack}, 32'd0);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          n_ack;
        int          first_ack;
        int          second_ack;
        int          n_idle;
        int          idle_cyc;

        reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; byteen = 4'd0;
        wdata = 32'd0; pc = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        // Reset during WAIT drops the store.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h10; byteen = 4'hF; wdata = 32'h12345678;
        @(posedge clk); #1;
        check("rstw_busy", {31'd0, busy}, 32'd1);
        check("rstw_ack1", {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        check("rstw_ack2", {31'd0, ack}, 32'd0);
        reset = 1'b1;
        #1;
        check("rstw_async_busy", {31'd0, busy}, 32'd0);
        req = 1'b0;
        @(posedge clk); #1;
        check("rstw_ack3", {31'd0, ack}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rstw_ack4", {31'd0, ack}, 32'd0);
        check("rstw_busy2", {31'd0, busy}, 32'd0);
        do_access("ld10", 1'b0, 32'h10, 4'hF, 32'd0, rd, e);
        check("ld10_data", rd, 32'h0);
        check("ld10_err", {31'd0, e}, 32'd0);

        // Full-word store and load.
        do_access("st0", 1'b1, 32'h0, 4'hF, 32'hDEADBEEF, rd, e);
        check("st0_err", {31'd0, e}, 32'd0);
        do_access("ld0", 1'b0, 32'h0, 4'h0, 32'd0, rd, e);
        check("ld0_data", rd, 32'hDEADBEEF);
        check("ld0_err", {31'd0, e}, 32'd0);

        // Partial store merge; low address bits ignored on the load.
        do_access("st4", 1'b1, 32'h4, 4'hF, 32'h11223344, rd, e);
        do_access("st4p", 1'b1, 32'h4, 4'b0101, 32'hAABBCCDD, rd, e);
        do_access("ld7", 1'b0, 32'h7, 4'hF, 32'd0, rd, e);
        check("ld7_data", rd, 32'h11BB33DD);

        // Out-of-range accesses and the last valid word.
        do_access("ld3000", 1'b0, 32'h3000, 4'hF, 32'd0, rd, e);
        check("ld3000_err", {31'd0, e}, 32'd1);
        check("ld3000_data", rd, 32'h0);
        do_access("st3000", 1'b1, 32'h3000, 4'hF, 32'h55555555, rd, e);
        check("st3000_err", {31'd0, e}, 32'd1);
        do_access("st2ffc", 1'b1, 32'h2FFC, 4'hF, 32'hCAFEF00D, rd, e);
        check("st2ffc_err", {31'd0, e}, 32'd0);
        do_access("ld2ffc", 1'b0, 32'h2FFC, 4'hF, 32'd0, rd, e);
        check("ld2ffc_data", rd, 32'hCAFEF00D);
        check("ld2ffc_err", {31'd0, e}, 32'd0);

        // Store with no lanes enabled still acks and leaves memory alone.
        do_access("st0z", 1'b1, 32'h0, 4'h0, 32'h99999999, rd, e);
        do_access("ld0b", 1'b0, 32'h0, 4'hF, 32'd0, rd, e);
        check("ld0b_data", rd, 32'hDEADBEEF);

        // Back-to-back stores with req held through the first ack.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h8; byteen = 4'hF; wdata = 32'hA1A1A1A1;
        n_ack = 0; first_ack = 0; second_ack = 0; n_idle = 0; idle_cyc = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin
                n_ack++;
                if (n_ack == 1) begin
                    first_ack = c;
                    addr = 32'hC;
                    wdata = 32'hB2B2B2B2;
                end else begin
                    second_ack = c;
                    req = 1'b0;
                end
            end
            if (c <= 7 && busy !== 1'b1) begin
                n_idle++;
                idle_cyc = c;
            end
        end
        check("b2b_ack_count", n_ack, 32'd2);
        check("b2b_first_ack", first_ack, 32'd3);
        check("b2b_second_ack", second_ack, 32'd7);
        check("b2b_idle_count", n_idle, 32'd1);
        check("b2b_idle_cycle", idle_cyc, 32'd4);
        check("b2b_busy_after", {31'd0, busy}, 32'd0);
        do_access("ld8", 1'b0, 32'h8, 4'hF, 32'd0, rd, e);
        check("ld8_data", rd, 32'hA1A1A1A1);
        do_access("ldc", 1'b0, 32'hC, 4'hF, 32'd0, rd, e);
        check("ldc_data", rd, 32'hB2B2B2B2);

        // Upper-lane store into a zeroed word (the trace example).
        pc = 32'h3004;
        do_access("st12", 1'b1, 32'h12, 4'b1100, 32'hABCD0000, rd, e);
        pc = 32'h0;
        do_access("ld10b", 1'b0, 32'h10, 4'hF, 32'd0, rd, e);
        check("ld10b_data", rd, 32'hABCD0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder for the pipelined MIPS core's load/store port. The core's MEM stage is the initiator; this block accepts word requests with byte enables.
- Each request completes after a fixed wait-state latency and returns a one-cycle ack carrying read data.
- Lets the CPU be run under the top-level bench against a memory that has real latency, not single-cycle combinational reads.

Parameters:
- WORDS, 3072, memory depth in 32-bit words (12 KiB); byte address space 0x0000_0000 to 4*WORDS-1.
- LATENCY, 2, cycles from request acceptance to ack; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request valid; initiator holds req and all request fields stable until ack.
- we  input  1  1 = store, 0 = load.
- addr  input  32  byte address; addr[1:0] ignored (word-aligned access).
- byteen  input  4  store byte lanes; byteen[i] selects wdata[8i+7:8i].
- wdata  input  32  store data, already lane-aligned by the core.
- pc  input  32  PC of the requesting instruction; used only by the trace feature.
- ack  output  1  one-cycle completion pulse.
- rdata  output  32  load data; valid in the ack cycle, held until the next ack.
- err  output  1  asserted with ack when the address is out of range.
- busy  output  1  high from acceptance until the ack cycle inclusive.

Behaviour:
- Reset is asynchronous, active-high.
  - Forces ack=0, rdata=0, err=0, busy=0, state=IDLE, count=0.
  - Clears every memory word to 0.
  - Reset mid-request drops the request; no write is performed.
- State machine:
  - IDLE: when req=1, latch we/addr/byteen/wdata/pc, load count=LATENCY-1, set busy=1, go WAIT.
  - WAIT: if count!=0, decrement and stay; if count==0, perform the access, go RESP.
  - RESP: ack=1 for exactly this cycle, busy=1, then go IDLE with busy=0.
- Latency: with req rising at edge N (acceptance), ack is high during the cycle after edge N+LATENCY+1. For LATENCY=2, ack appears 3 cycles after acceptance.
- Access:
  - Word index = addr[31:2].
  - Out of range (index >= WORDS): no write; rdata=0; err=1 in the ack cycle.
  - Store: for each i with byteen[i]=1, mem[idx][8i+7:8i] <= wdata[8i+7:8i]. byteen=0 still acks, with no change to memory.
  - Load: rdata <= full word mem[idx]; byteen is ignored. The core does lane extraction.
- Request fields are sampled only at acceptance. Changes to them during WAIT or RESP are ignored.
- req held high through the ack cycle is treated as a new request. It is accepted in the following IDLE cycle, so back-to-back requests are spaced by at least one idle cycle.
- A store followed by a load to the same word returns the merged data (no bypass is needed, because accesses are serialized).

Optional Feature:
- Macro DM_TRACE_EN.
- Defined: on every committed in-range store with byteen!=0, print one line in the ack cycle: $display("%d@%h: *%h <= %h", $time, pc_latched, {idx,2'b00}, merged_word). The printed word is the full word after the merge.
- Undefined: no $display calls, and pc is unused (no logic depends on it).

Decomposition:
- Package dm_pkg holds:
  - state typedef {IDLE, WAIT, RESP};
  - DM_WORD_BITS=32;
  - the default DM_WORDS=3072.
- One sub-module, dm_byte_merge: combinational old word + wdata + byteen -> merged word. It is reused by the core's load/store unit tests.

Test Plan:
- Reset mid-WAIT: issue store 0x12345678 to 0x10 with byteen=4'hF, pulse reset in WAIT, then load 0x10 -> rdata=0, with no ack before the load.
- Full store/load at LATENCY=2: store 0xDEADBEEF to 0x0 with byteen=4'hF, then load 0x0 -> rdata=0xDEADBEEF and err=0. Each ack arrives 3 cycles after acceptance and is 1 cycle wide.
- Partial store: mem[0x4]=0x11223344, store wdata=0xAABBCCDD with byteen=4'b0101, then load 0x4 -> 0x11BB33DD.
- Out of range: load 0x3000 -> ack with err=1 and rdata=0. Store 0x3000 -> ack with err=1; a subsequent load of 0x0 is unchanged.
- Back-to-back: req held high for two stores (0x8, then 0xC). Exactly two acks, separated by one IDLE cycle; busy=0 only in the gap cycle.
- Trace (DM_TRACE_EN defined): store pc=0x3004, addr=0x12, byteen=4'b1100, wdata=0xABCD0000 into a zeroed word -> output line "@00003004: *00000010 <= abcd0000".
